// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, decode-stage redirects (branch/jump/register),
// stall-deferred redirects via a pending target, and a fault vector for misaligned register targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] FAULT_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redir_valid,
  output logic        redir_ready,
  input  logic [1:0]  redir_kind,
  input  logic        redir_taken,
  input  logic [31:0] redir_instr,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_reg,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        fault_q, fault_d;

  logic        accept_s;
  logic        effective_s;
  logic        misalign_s;
  logic [31:0] target_s;
  logic [31:0] br_target_s;
  logic [31:0] jmp_target_s;
  logic        unused_instr_hi_s;

  assign unused_instr_hi_s = ^redir_instr[31:26];

  // Redirect decode: candidate target and whether the accepted redirect changes the PC
  always_comb begin
    br_target_s  = redir_pc + 32'd4 + {{14{redir_instr[15]}}, redir_instr[15:0], 2'b00};
    jmp_target_s = {redir_pc[31:28], redir_instr[25:0], 2'b00};
    accept_s     = redir_valid && (state_q == RUN);
    effective_s  = 1'b0;
    target_s     = br_target_s;
    case (redir_kind)
      2'b00: begin
        effective_s = redir_taken;
        target_s    = br_target_s;
      end
      2'b01: begin
        effective_s = 1'b1;
        target_s    = jmp_target_s;
      end
      2'b10: begin
        effective_s = 1'b1;
        target_s    = redir_reg;
      end
      default: begin
        effective_s = 1'b0;
        target_s    = br_target_s;
      end
    endcase
    misalign_s = accept_s && (redir_kind == 2'b10) && (redir_reg[1:0] != 2'b00);
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    fault_d = 1'b0;
    case (state_q)
      RUN: begin
        if (misalign_s) begin
          // Fault vector wins over a concurrent stall
          pc_d    = FAULT_PC;
          fault_d = 1'b1;
          state_d = FLUSH;
        end else if (accept_s && effective_s) begin
          if (stall) begin
            pend_d  = target_s;
            state_d = PEND;
          end else begin
            pc_d = target_s;
          end
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end else begin
          pc_d = pc_q;
        end
      end
      PEND: begin
        if (!stall) begin
          pc_d    = pend_q;
          state_d = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      FLUSH: begin
        state_d = RUN;
        if (!stall) begin
          pc_d = pc_q + 32'd4;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = RUN;
        pc_d    = pc_q;
      end
    endcase
  end

  // State, PC, pending target and fault registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fault       = fault_q;
  assign redir_ready = (state_q == RUN);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have parameter FAULT_PC, default 32'h0000_4180, PC loaded on a misaligned register target.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  hold the fetch PC when high (IF/ID freeze).
REQ-006 SHALL have port redir_valid  input  1  redirect request from decode stage.
REQ-007 SHALL have port redir_ready  output  1  redirect can be accepted this cycle.
REQ-008 SHALL have port redir_kind  input  2  00 branch16, 01 jump26, 10 register, 11 reserved.
REQ-009 SHALL have port redir_taken  input  1  branch condition result; ignored for kinds 01/10.
REQ-010 SHALL have port redir_instr  input  32  instruction word carrying the imm16/index26 field.
REQ-011 SHALL have port redir_pc  input  32  PC of the redirecting instruction.
REQ-012 SHALL have port redir_reg  input  32  register target for kind 10.
REQ-013 SHALL have port pc  output  32  current fetch PC.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 SHALL have port fault  output  1  one-cycle pulse on a misaligned register target.

Function
REQ-016 Handshake: SHALL accept a redirect in any cycle where redir_valid && redir_ready.
REQ-017 Targets: kind 00 SHALL be redir_pc + 4 + (sign-extended instr[15:0] << 2); kind 01 SHALL be {redir_pc[31:28], instr[25:0], 2'b00}; kind 10 SHALL be redir_reg. All arithmetic is 32-bit with wrap-around.
REQ-018 An accepted kind 00 with redir_taken=0, or any accepted kind 11, SHALL be consumed as a no-op: no PC change, no fault.
REQ-019 State machine SHALL have states RUN, PEND, FLUSH.
REQ-020 RUN, stall=0, no accept: pc <= pc + 4.
REQ-021 RUN, stall=0, effective redirect accepted: pc <= target on the next edge (one-cycle latency; the fetch in the accept cycle is the delay slot).
REQ-022 RUN, stall=1, effective redirect accepted: pc held, target latched into the pending register, go to PEND.
REQ-023 PEND: redir_ready SHALL be 0 and pc held while stall=1. When stall=0: pc <= pending target, return to RUN.
REQ-024 Misaligned kind 10 target (redir_reg[1:0] != 0), accepted: pc <= FAULT_PC, fault=1 for exactly that edge's cycle, go to FLUSH. A stall in that cycle SHALL be overridden.
REQ-025 FLUSH: redir_ready=0 for one cycle, pc <= pc + 4 unless stall, then return to RUN.
REQ-026 redir_ready SHALL be 1 only in RUN.
REQ-027 In RUN with stall=1 and no accept, pc SHALL hold.
REQ-028 pc_plus4 SHALL be combinational from pc.
REQ-029 pc SHALL always be word-aligned; kinds 00/01 are aligned by construction.

Reset
REQ-030 When reset_n=0, the block SHALL immediately (asynchronously) set pc=RESET_PC, state=RUN, fault=0, and the pending register to 0.
REQ-031 A reset asserted in PEND or FLUSH SHALL discard the pending or flush state; no redirect is applied after reset release.
REQ-032 On the first edge after reset release with stall=0 and no redirect, pc SHALL become RESET_PC + 4.

Verification
REQ-033 Reset and sequential fetch: release reset, stall=0 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-034 Taken backward branch: redir_pc=0x3010, instr[15:0]=16'hFFFC, kind 00, taken=1, stall=0 -> next pc = 0x3004.
REQ-035 Jump: redir_pc=0x0000_3020, instr[25:0]=26'h0000C10, kind 01 -> next pc = 0x0000_3040. Not-taken branch -> pc = previous + 4.
REQ-036 Redirect under stall: kind 10, reg=0x0000_3100, stall=1 for 3 cycles -> pc held, redir_ready=0 during PEND; the edge after stall falls gives pc = 0x3100.
REQ-037 Misaligned register target: kind 10, reg=0x0000_3102 -> pc = 0x4180, fault high for exactly one cycle, redir_ready=0 for one cycle, then pc = 0x4184.
REQ-038 Async reset mid-PEND: assert reset_n=0 between edges -> pc = 0x3000 before the next edge; the pending target is never applied.
